operand_issuer: RTL

OPERAND_ISSUER -- requirements
Module: operand_issuer

---
 rtl/operand_issuer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/operand_issuer.sv
// operand_issuer: queues operand pairs in a small FIFO and issues them one at a time to a
// downstream adder stage, capturing each result into a single-entry output register.
// Optional macro ISSUE_TIMEOUT_EN adds a WAIT-state watchdog that drops a stalled operation
// and raises the sticky err_timeout flag; without it err_timeout is constant 0.
module operand_issuer #(
   parameter int unsigned W       = 8,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 7
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   output logic         start,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   input  logic         res_valid,
   input  logic [W-1:0] res_y,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_y,
   output logic         err_spurious,
   output logic         err_timeout
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FullCount = DEPTH[AW:0];

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two and at least 2");
   end
   if (TIMEOUT < 2) begin : g_bad_timeout
      $error("TIMEOUT must be at least 2");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   logic [W-1:0]  mem_a [DEPTH];
   logic [W-1:0]  mem_b [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;
   logic          rdy_q;
   logic          full, empty, push, pop;

   state_e        state_q;
   logic          start_q, out_valid_q, err_spur_q;
   logic [W-1:0]  a_q, b_q, out_y_q;

   // No bypass: a full FIFO refuses a push even when the head pops this cycle.
   // rdy_q keeps in_ready low until the first edge after reset release.
   assign full     = (count_q == FullCount);
   assign empty    = (count_q == '0);
   assign in_ready = rdy_q & ~full;
   assign push     = in_valid & in_ready;
   assign pop      = (state_q == StIssue);

   // FIFO storage; contents need no reset since occupancy is tracked separately.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr_q] <= in_a;
         mem_b[wr_ptr_q] <= in_b;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         rdy_q    <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef ISSUE_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT);
   logic [CW-1:0] wait_cnt_q;
   logic          err_to_q;
   assign err_timeout = err_to_q;
`else
   assign err_timeout = 1'b0;
`endif

   // Issue FSM with registered outputs; exactly one operation in flight at a time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         start_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         err_spur_q  <= 1'b0;
`ifdef ISSUE_TIMEOUT_EN
         wait_cnt_q  <= '0;
         err_to_q    <= 1'b0;
`endif
      end else begin
         start_q <= 1'b0;
         if (res_valid && state_q != StWait) err_spur_q  <= 1'b1;
         if (out_valid_q && out_ready)       out_valid_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               // Issue only when the output slot is free or being drained this cycle.
               if (!empty && (!out_valid_q || out_ready)) begin
                  state_q <= StIssue;
                  start_q <= 1'b1;
                  a_q     <= mem_a[rd_ptr_q];
                  b_q     <= mem_b[rd_ptr_q];
               end
            end
            StIssue: begin
               state_q <= StWait;
`ifdef ISSUE_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end
            StWait: begin
               if (res_valid) begin
                  out_y_q     <= res_y;
                  out_valid_q <= 1'b1;
                  state_q     <= StIdle;
               end
`ifdef ISSUE_TIMEOUT_EN
               else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                  err_to_q <= 1'b1;
                  state_q  <= StIdle;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
`endif
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign start        = start_q;
   assign a            = a_q;
   assign b            = b_q;
   assign out_valid    = out_valid_q;
   assign out_y        = out_y_q;
   assign err_spurious = err_spur_q;

endmodule
